ltc2308_scan_sequencer: RTL and testbench

- Autonomous scan controller for the LTC2308 8-channel SPI ADC on the DE1-SoC. Drives CONVST/SCK/SDI and captures SDO.
- Cycles through the channels enabled in a mask and stores the latest 12-bit result per channel in a readable bank.
- Emits a result strobe for each conversion.
- Replaces software bit-banging; sits between the Avalon slave wrapper and the adc_ltc2308 conduit pins.

---
 rtl/ltc2308_scan_sequencer.sv | 135 +++++++++++++
 tb/tb_ltc2308_scan_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2308_scan_sequencer.sv
// Autonomous LTC2308 scan controller: walks the enabled channels in chan_mask,
// runs one CONVST/SPI frame per channel and keeps the latest result per channel.
module ltc2308_scan_sequencer #(
  parameter int CLK_DIV     = 2,
  parameter int CONVST_HIGH = 2,
  parameter int CONV_CYCLES = 80,
  parameter bit UNIPOLAR    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  chan_mask,
  input  logic [2:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic        result_valid,
  output logic [2:0]  result_chan,
  output logic [11:0] result_data,
  output logic        busy,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo
);

  localparam int CW = 16;

  typedef enum logic [2:0] {IDLE, CONVST, WAIT, SHIFT, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          sck_ph;
  logic [3:0]    bit_idx;
  logic [2:0]    cur_chan, prev_chan, next_chan;
  logic          primed;
  logic [11:0]   shreg;
  logic [11:0]   bank [8];
  logic [5:0]    cfg;
  logic          run, half_end, sample, shift_end, start;

  assign run       = enable && (chan_mask != 8'd0);
  assign half_end  = (cnt == CW'(CLK_DIV - 1));
  assign sample    = (state == SHIFT) && sck_ph && half_end;
  assign shift_end = sample && (bit_idx == 4'd11);
  assign start     = (state_n == CONVST) && ((state == IDLE) || (state == DONE));
  assign cfg       = {1'b1, cur_chan[0], cur_chan[2], cur_chan[1], UNIPOLAR, 1'b0};
  assign rd_data   = bank[rd_addr];

  // Round-robin: lowest enabled channel strictly above cur_chan, wrapping.
  always_comb begin
    logic [2:0] c;
    logic       found;
    c         = '0;
    found     = 1'b0;
    next_chan = cur_chan;
    for (int i = 1; i <= 8; i++) begin
      c = cur_chan + 3'(i);
      if (!found && chan_mask[c]) begin
        next_chan = c;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (run) state_n = CONVST;
      CONVST:  if (cnt == CW'(CONVST_HIGH - 1)) state_n = WAIT;
      WAIT:    if (cnt == CW'(CONV_CYCLES - 1)) state_n = SHIFT;
      SHIFT:   if (shift_end) state_n = DONE;
      DONE:    state_n = run ? CONVST : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    adc_convst = (state == CONVST);
    adc_sck    = (state == SHIFT) && sck_ph;
    adc_sdi    = 1'b0;
    if ((state == SHIFT) && (bit_idx < 4'd6))
      adc_sdi = cfg[3'(4'd5 - bit_idx)];
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      sck_ph       <= 1'b0;
      bit_idx      <= '0;
      shreg        <= '0;
      cur_chan     <= 3'd7;
      prev_chan    <= '0;
      primed       <= 1'b0;
      result_valid <= 1'b0;
      result_chan  <= '0;
      result_data  <= '0;
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else begin
      if ((state != state_n) || (state == IDLE) || ((state == SHIFT) && half_end))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state != SHIFT) begin
        sck_ph  <= 1'b0;
        bit_idx <= '0;
      end else if (half_end) begin
        sck_ph <= ~sck_ph;
        if (sck_ph) bit_idx <= bit_idx + 1'b1;
      end

      if (sample) shreg <= {shreg[10:0], adc_sdo};
      if (start)  cur_chan <= next_chan;

      // Result is presented during DONE; the bank takes it at the end of DONE.
      result_valid <= shift_end && primed;
      if (shift_end && primed) begin
        result_chan <= prev_chan;
        result_data <= {shreg[10:0], adc_sdo};
      end

      if (state == DONE) begin
        if (primed) bank[prev_chan] <= result_data;
        primed    <= (state_n == CONVST);
        prev_chan <= cur_chan;
      end
    end
  end

endmodule

// File: tb/tb_ltc2308_scan_sequencer.sv
// Directed bench for ltc2308_scan_sequencer with a behavioural LTC2308 model
// and a result scoreboard.
module tb_ltc2308_scan_sequencer;

  logic        clk, reset, enable;
  logic [7:0]  chan_mask;
  logic [2:0]  rd_addr;
  logic [11:0] rd_data;
  logic        result_valid;
  logic [2:0]  result_chan;
  logic [11:0] result_data;
  logic        busy, adc_convst, adc_sck, adc_sdi, adc_sdo;

  ltc2308_scan_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask),
    .rd_addr(rd_addr), .rd_data(rd_data), .result_valid(result_valid),
    .result_chan(result_chan), .result_data(result_data), .busy(busy),
    .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];
  logic [5:0]  cfg_q [$];

  logic [11:0] model_val [8];
  logic [5:0]  shcfg = '0, last_cfg = '0;
  logic [11:0] sdo_word = '0;
  int          nfall = 12;
  int          cyc = 0, last_rise = 0, mon_rises = 0, sck_period = 0;
  int          conv_run = 0, conv_len = 0;
  logic        cv_d = 1'b0, sck_d = 1'b0;

  function automatic logic [5:0] cfgw(input int c);
    logic [2:0] ch;
    ch = 3'(c);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
  endfunction

  // ADC model: each frame returns the conversion of the previous frame's config.
  always @(posedge adc_convst) begin
    sdo_word = model_val[{last_cfg[3], last_cfg[2], last_cfg[4]}];
    nfall    = 0;
  end
  always @(negedge adc_sck) if (nfall < 12) nfall++;
  assign adc_sdo = (nfall < 12) ? sdo_word[4'(11 - nfall)] : 1'b0;

  // Pin / strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (adc_convst && !cv_d) mon_rises = 0;
    if (adc_convst) conv_run++;
    else if (conv_run != 0) begin conv_len = conv_run; conv_run = 0; end
    if (adc_sck && !sck_d) begin
      mon_rises++;
      if (mon_rises > 1) sck_period = cyc - last_rise;
      last_rise = cyc;
      if (mon_rises <= 6) shcfg = {shcfg[4:0], adc_sdi};
      if (mon_rises == 6) begin cfg_q.push_back(shcfg); last_cfg = shcfg; end
    end
    if (result_valid) got_q.push_back({17'b0, result_chan, result_data});
    cv_d = adc_convst;
    sck_d = adc_sck;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    got_q.delete(); exp_q.delete(); cfg_q.delete();
  endtask

  task automatic sb_drain(input string tag);
    logic [31:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      chk(tag, g, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!result_valid && n < 600);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk("idle_reached", busy, 0);
  endtask

  task automatic wait_sck_high(input string tag);
    int n = 0;
    while (!adc_sck && n < 300) begin @(negedge clk); n++; end
    chk(tag, adc_sck, 1);
  endtask

  task automatic wait_cfgs(input int k);
    int n = 0;
    while (cfg_q.size() < k && n < 600) begin @(negedge clk); n++; end
    chk("cfg_count", (cfg_q.size() >= k), 1);
  endtask

  initial begin
    int n, bad;
    for (int i = 0; i < 8; i++) model_val[i] = 12'(12'h100 + i);
    reset = 1'b1; enable = 1'b0; chan_mask = 8'h00; rd_addr = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_pins", {adc_convst, adc_sck, adc_sdi}, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_rd", rd_data, 0);
    reset = 1'b0;

    // Single channel 0, first-result latency and frame timing.
    clear_q();
    model_val[0] = 12'hABC;
    exp_q.push_back({17'b0, 3'd0, 12'hABC});
    chan_mask = 8'h01; rd_addr = 3'd0; enable = 1'b1;
    wait_strobe(n);
    chk("t1_latency", n, 262);
    chk("t1_chan", result_chan, 0);
    chk("t1_data", result_data, 12'hABC);
    chk("t1_rd_old", rd_data, 0);
    chk("t1_sck_rises", mon_rises, 12);
    chk("t1_convst_len", conv_len, 2);
    chk("t1_sck_period", sck_period, 4);
    chk("t1_cfg0", cfg_q[0], cfgw(0));
    chk("t1_cfg1", cfg_q[1], cfgw(0));
    @(negedge clk);
    chk("t1_rd_new", rd_data, 12'hABC);
    chk("t1_pulse", result_valid, 0);
    sb_drain("t1_sb");
    enable = 1'b0;
    wait_idle();

    // Mask 0x91 from reset: order 0,4,7.
    do_reset();
    clear_q();
    for (int i = 0; i < 8; i++) model_val[i] = 12'(12'h100 + i);
    exp_q.push_back({17'b0, 3'd0, 12'h100});
    exp_q.push_back({17'b0, 3'd4, 12'h104});
    exp_q.push_back({17'b0, 3'd7, 12'h107});
    chan_mask = 8'h91; enable = 1'b1;
    n = 0;
    while (got_q.size() < 3 && n < 900) begin @(negedge clk); n++; end
    @(negedge clk);
    enable = 1'b0;
    sb_drain("t2_sb");
    chk("t2_cfg0", cfg_q[0], cfgw(0));
    chk("t2_cfg1", cfg_q[1], cfgw(4));
    chk("t2_cfg2", cfg_q[2], cfgw(7));
    chk("t2_cfg3", cfg_q[3], cfgw(0));
    wait_idle();

    // Empty mask stays idle; then mask 0x08 starts on ch3.
    clear_q();
    chan_mask = 8'h00; enable = 1'b1; bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy || adc_convst || adc_sck || adc_sdi) bad++;
    end
    chk("t3_quiet", bad, 0);
    chan_mask = 8'h08;
    wait_cfgs(1);
    chk("t3_cfg_ch3", cfg_q[0], cfgw(3));
    enable = 1'b0;
    wait_idle();

    // Disable during SHIFT of frame 3, then re-prime on re-enable.
    do_reset();
    clear_q();
    chan_mask = 8'h01; enable = 1'b1;
    wait_strobe(n);
    wait_sck_high("t4_frame3_shift");
    enable = 1'b0;
    wait_strobe(n);
    chk("t4_late_strobe", result_valid, 1);
    chk("t4_late_chan", result_chan, 0);
    wait_idle();
    repeat (150) @(negedge clk);
    chk("t4_strobe_count", got_q.size(), 2);
    enable = 1'b1;
    wait_strobe(n);
    chk("t4_reprime_latency", n, 262);
    enable = 1'b0;
    wait_idle();

    // Mask change during WAIT takes effect on the next frame.
    clear_q();
    chan_mask = 8'h01; enable = 1'b1;
    n = 0;
    while (!adc_convst && n < 50) begin @(negedge clk); n++; end
    while (adc_convst && n < 50) begin @(negedge clk); n++; end
    chk("t5_in_wait", {busy, adc_convst, adc_sck}, 3'b100);
    chan_mask = 8'h02;
    wait_cfgs(2);
    chk("t5_cfg0", cfg_q[0], cfgw(0));
    chk("t5_cfg1", cfg_q[1], cfgw(1));
    enable = 1'b0;
    wait_idle();

    // Async reset during SHIFT clears pins and bank.
    do_reset();
    clear_q();
    model_val[1] = 12'h5A5;
    chan_mask = 8'h02; rd_addr = 3'd1; enable = 1'b1;
    wait_strobe(n);
    @(negedge clk);
    chk("t6_bank1", rd_data, 12'h5A5);
    wait_sck_high("t6_shift");
    reset = 1'b1;
    #1;
    chk("t6_pins", {adc_convst, adc_sck, adc_sdi}, 0);
    chk("t6_busy", busy, 0);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      chk("t6_rd_clear", rd_data, 0);
    end
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_valid", result_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
